usb_crypt_seq: RTL and testbench
================================

# usb_crypt_seq

Parametrised packet sequencer for the USB encryption datapath. It accepts bit-order-corrected packets from the receive side, validates the PID, and routes DATA0/DATA1 payloads through the DES engine one 64-bit block at a time using a start/done handshake, so encryption latency is variable rather than timer-fixed. Finished packets are queued in a DEPTH-entry buffer and handed to the USB writer over a valid/ready handshake. It replaces the fixed-delay sequencing timers and the single-packet combiner with a multi-block, buffered, back-pressure-aware stage.

## Interface
- BLOCKS, 1: 64-bit payload blocks per data packet, legal range 1..8.
- DEPTH, 2: output buffer entries, power of 2, at least 2.
- ENC_TIMEOUT, 255: maximum cycles to wait for enc_done, legal range 1..65535.

- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- rx_valid  in  1  one-cycle pulse: packet captured (EOP).
- rx_pid  in  8  PID byte; PID[3:0] in bits [3:0], check nibble in bits [7:4].
- rx_payload  in  64*BLOCKS  payload; block i is bits [64i+63:64i].
- rx_crc  in  16  received CRC16, passed through for token/handshake packets.
- rx_crc_ok  in  1  received-CRC check result; sampled with rx_valid.
- mode  in  1  1 = encrypt, 0 = decrypt; sampled with rx_valid.
- enc_start  out  1  one-cycle pulse to the engine.
- enc_mode  out  1  mode latched for the packet.
- enc_din  out  64  block being processed.
- enc_done  in  1  engine result valid.
- enc_dout  in  64  engine result.
- tx_valid / tx_ready  out / in  1 / 1  output handshake.
- tx_pid  out  8; tx_payload  out  64*BLOCKS; tx_crc  out  16.
- tx_kind  out  2  00 = token, 01 = data, 10 = handshake.
- drop_cnt  out  8  saturating count of discarded packets.
- busy  out  1  high whenever the FSM is not in IDLE.

## Operation
- PID is valid when rx_pid[7:4] == ~rx_pid[3:0].
  - Data packets: DATA0 8'hC3, DATA1 8'h4B.
  - Tokens: 8'hE1, 8'h69, 8'h2D, 8'hA5.
  - Handshakes: 8'hD2, 8'h5A, 8'h1E.
  - Any other byte, including a valid but unlisted PID, is dropped.
- A packet is dropped (drop_cnt +1, saturating at 255) in any of these cases:
  - rx_valid arrives while busy = 1 (overrun).
  - The PID is invalid.
  - A data packet arrives with rx_crc_ok = 0.
  - The engine times out.
- FSM states: IDLE, ISSUE, WAIT, CRC, PUSH.
  - IDLE: accepted data packet goes to ISSUE (block 0); accepted token or handshake goes to PUSH; drops stay in IDLE.
  - ISSUE: assert enc_start for one cycle, then go to WAIT.
  - WAIT: on enc_done, store enc_dout into block i; if i < BLOCKS-1, go to ISSUE (i+1), else go to CRC. A counter reaching ENC_TIMEOUT without enc_done drops the packet and returns to IDLE.
  - CRC: generates the output CRC (see Configuration), then goes to PUSH.
  - PUSH: writes the packet to the buffer when it is not full, or when a pop occurs in the same cycle; otherwise holds (back-pressure). Then returns to IDLE.
- enc_done outside WAIT is ignored.
- Buffer behaviour:
  - tx_valid = !empty; the buffer head drives tx_*.
  - Pop on tx_valid & tx_ready.
  - Read and write pointers wrap modulo DEPTH.
  - full/empty are tracked by a count held in clog2(DEPTH)+1 bits.

## Timing
- Reset values:
  - enc_start 0, enc_mode 0, enc_din 0.
  - tx_valid 0, tx_pid 0, tx_payload 0, tx_crc 0, tx_kind 0.
  - drop_cnt 0, busy 0; FSM in IDLE; buffer empty.
- Reset mid-operation discards the packet in flight and all buffered packets; a later enc_done is ignored.
- rx_valid in IDLE (cycle T): enc_start at T+1; block 0 is already on enc_din at T+1.
- enc_done at cycle D: next enc_start at D+2.
- Token/handshake path: PUSH at T+1; tx_valid at T+2 if the buffer was empty.
- Data path: the CRC state takes 8*BLOCKS cycles with the macro defined, 1 cycle without.
- Timeout: WAIT is abandoned on its ENC_TIMEOUT-th cycle.
- tx_* are held stable while tx_valid & !tx_ready.

## Configuration
- USB_CRYPT_CRC16_EN defined: the output CRC16 is recomputed over the processed payload.
  - Bytes in order byte 0 = rx_payload[7:0] upward, LSB-first within each byte.
  - Reflected polynomial 16'hA001, init 16'hFFFF, final result inverted.
  - One byte per cycle.
- USB_CRYPT_CRC16_EN undefined: tx_crc = 16'hFFFF for data packets, and CRC lasts 1 cycle.

## Structure
- Package usb_crypt_pkg holds:
  - PID constants.
  - tx_kind and FSM state enums.
  - CRC16 polynomial and init constants.
  - Function crc16_byte(crc, byte).
- Sub-module usb_pkt_fifo: DEPTH-entry register buffer with push/pop/full/empty; entry = {kind, pid, payload, crc}.

## Test plan
- DATA0 8'hC3, BLOCKS=2, engine done 5 cycles after each start -> two enc_start pulses; tx_kind 01; tx_payload = engine outputs in block order; tx_crc = 16'hFFFF with the macro undefined.
- With the macro defined, single block, engine echoes its input, payload 64'h0 -> tx_crc equals the reference CRC16 of 8 zero bytes.
- Token 8'h69 with rx_crc 16'h1234 -> tx_valid at T+2, tx_kind 00, tx_crc 16'h1234, no enc_start.
- PID 8'hC4, then DATA1 8'h4B with rx_crc_ok = 0 -> drop_cnt = 2, no tx_valid.
- DEPTH=2, tx_ready = 0, three tokens sent -> third stalls in PUSH with busy = 1; a fourth rx_valid increments drop_cnt; raising tx_ready drains the buffer in order.
- ENC_TIMEOUT=16 with enc_done never asserted -> drop_cnt +1 and IDLE reached after 16 WAIT cycles; rst during WAIT clears everything, and a subsequent enc_done is ignored.

Source files
------------

// File: rtl/usb_crypt_pkg.sv
// Shared PID constants, packet/FSM enums and the reflected CRC16 byte step used by the
// USB encryption sequencer.
package usb_crypt_pkg;

    localparam logic [7:0] PidData0 = 8'hC3;
    localparam logic [7:0] PidData1 = 8'h4B;
    localparam logic [7:0] PidOut   = 8'hE1;
    localparam logic [7:0] PidIn    = 8'h69;
    localparam logic [7:0] PidSetup = 8'h2D;
    localparam logic [7:0] PidSof   = 8'hA5;
    localparam logic [7:0] PidAck   = 8'hD2;
    localparam logic [7:0] PidNak   = 8'h5A;
    localparam logic [7:0] PidStall = 8'h1E;

    localparam logic [15:0] Crc16Poly = 16'hA001;
    localparam logic [15:0] Crc16Init = 16'hFFFF;

    typedef enum logic [1:0] {
        KindToken     = 2'b00,
        KindData      = 2'b01,
        KindHandshake = 2'b10
    } tx_kind_e;

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWait,
        StCrc,
        StPush
    } state_e;

    // One byte through the reflected CRC16, LSB first.
    function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] data);
        logic [15:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ data[i]) begin
                c = (c >> 1) ^ Crc16Poly;
            end else begin
                c = c >> 1;
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/usb_pkt_fifo.sv
// DEPTH-entry register buffer for finished packets; head is presented combinationally and
// reads as zero while empty.
module usb_pkt_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wptr_q, rptr_q;
    logic [CntW-1:0]  cnt_q;
    logic             do_push, do_pop;

    assign full    = (cnt_q == CntW'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign do_pop  = pop && !empty;
    // A full buffer still accepts a write when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign rdata   = empty ? '0 : mem_q[rptr_q];

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
            cnt_q <= cnt_q + CntW'(do_push) - CntW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= wdata;
    end

endmodule

// File: rtl/usb_crypt_seq.sv
// Packet sequencer: validates PIDs, runs data payloads block-by-block through the DES engine
// and buffers results for the USB writer. USB_CRYPT_CRC16_EN enables output CRC16 regeneration.
module usb_crypt_seq
    import usb_crypt_pkg::*;
#(
    parameter int unsigned BLOCKS      = 1,
    parameter int unsigned DEPTH       = 2,
    parameter int unsigned ENC_TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_pid,
    input  logic [64*BLOCKS-1:0]  rx_payload,
    input  logic [15:0]           rx_crc,
    input  logic                  rx_crc_ok,
    input  logic                  mode,
    output logic                  enc_start,
    output logic                  enc_mode,
    output logic [63:0]           enc_din,
    input  logic                  enc_done,
    input  logic [63:0]           enc_dout,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic [7:0]            tx_pid,
    output logic [64*BLOCKS-1:0]  tx_payload,
    output logic [15:0]           tx_crc,
    output logic [1:0]            tx_kind,
    output logic [7:0]            drop_cnt,
    output logic                  busy
);

    localparam int unsigned PayW = 64 * BLOCKS;
    localparam int unsigned IdxW = (BLOCKS > 1) ? $clog2(BLOCKS) : 1;
    localparam int unsigned EntW = 2 + 8 + PayW + 16;

    state_e          state_q, state_d;
    logic [IdxW-1:0] idx_q, idx_d;
    logic [15:0]     cnt_q, cnt_d;
    logic [PayW-1:0] pay_q, pay_d;
    logic [7:0]      pid_q, pid_d;
    tx_kind_e        kind_q, kind_d;
    logic [15:0]     crc_q, crc_d;
    logic            mode_q, mode_d;
    logic            start_q, start_d;
    logic [7:0]      drop_cnt_q, drop_cnt_d;
    logic [8:0]      drop_sum;
    logic            drop_rx, drop_to, push, pop;
    logic            pid_chk, is_data, is_token, is_hshake;
    logic            fifo_full, fifo_empty;
    logic [EntW-1:0] fifo_wdata, fifo_rdata;

`ifdef USB_CRYPT_CRC16_EN
    localparam int unsigned ByteW = $clog2(8 * BLOCKS);
    logic [ByteW-1:0] byte_q, byte_d;
    logic [7:0]       crc_byte;

    always_comb begin
        crc_byte = 8'h00;
        for (int k = 0; k < 8 * BLOCKS; k++) begin
            if (byte_q == ByteW'(k)) crc_byte = pay_q[k*8 +: 8];
        end
    end
`endif

    assign pid_chk   = (rx_pid[7:4] == ~rx_pid[3:0]);
    assign is_data   = pid_chk && (rx_pid inside {PidData0, PidData1});
    assign is_token  = pid_chk && (rx_pid inside {PidOut, PidIn, PidSetup, PidSof});
    assign is_hshake = pid_chk && (rx_pid inside {PidAck, PidNak, PidStall});

    always_comb begin
        enc_din = '0;
        for (int b = 0; b < BLOCKS; b++) begin
            if (idx_q == IdxW'(b)) enc_din = pay_q[b*64 +: 64];
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        pay_d   = pay_q;
        pid_d   = pid_q;
        kind_d  = kind_q;
        crc_d   = crc_q;
        mode_d  = mode_q;
        start_d = 1'b0;
        drop_rx = 1'b0;
        drop_to = 1'b0;
        push    = 1'b0;
`ifdef USB_CRYPT_CRC16_EN
        byte_d  = byte_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (rx_valid) begin
                    if (is_data && rx_crc_ok) begin
                        pid_d   = rx_pid;
                        pay_d   = rx_payload;
                        mode_d  = mode;
                        kind_d  = KindData;
                        idx_d   = '0;
                        start_d = 1'b1;
                        state_d = StIssue;
                    end else if (is_token || is_hshake) begin
                        pid_d   = rx_pid;
                        pay_d   = rx_payload;
                        crc_d   = rx_crc;
                        if (is_token) kind_d = KindToken;
                        else          kind_d = KindHandshake;
                        state_d = StPush;
                    end else begin
                        drop_rx = 1'b1;
                    end
                end
            end
            StIssue: begin
                // Entered from WAIT the strobe is raised one cycle late so enc_din settles first.
                if (start_q) begin
                    cnt_d   = '0;
                    state_d = StWait;
                end else begin
                    start_d = 1'b1;
                end
            end
            StWait: begin
                if (enc_done) begin
                    for (int b = 0; b < BLOCKS; b++) begin
                        if (idx_q == IdxW'(b)) pay_d[b*64 +: 64] = enc_dout;
                    end
                    if (idx_q == IdxW'(BLOCKS - 1)) begin
                        crc_d   = Crc16Init;
`ifdef USB_CRYPT_CRC16_EN
                        byte_d  = '0;
`endif
                        state_d = StCrc;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = StIssue;
                    end
                end else if (cnt_q == 16'(ENC_TIMEOUT - 1)) begin
                    drop_to = 1'b1;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StCrc: begin
`ifdef USB_CRYPT_CRC16_EN
                crc_d = crc16_byte(crc_q, crc_byte);
                if (byte_q == ByteW'(8 * BLOCKS - 1)) begin
                    crc_d   = ~crc16_byte(crc_q, crc_byte);
                    state_d = StPush;
                end else begin
                    byte_d = byte_q + 1'b1;
                end
`else
                crc_d   = 16'hFFFF;
                state_d = StPush;
`endif
            end
            StPush: begin
                if (!fifo_full || pop) begin
                    push    = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        if (rx_valid && state_q != StIdle) drop_rx = 1'b1;
    end

    assign drop_sum   = {1'b0, drop_cnt_q} + {8'b0, drop_rx} + {8'b0, drop_to};
    assign drop_cnt_d = drop_sum[8] ? 8'hFF : drop_sum[7:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            idx_q      <= '0;
            cnt_q      <= '0;
            pay_q      <= '0;
            pid_q      <= '0;
            kind_q     <= KindToken;
            crc_q      <= '0;
            mode_q     <= 1'b0;
            start_q    <= 1'b0;
            drop_cnt_q <= '0;
`ifdef USB_CRYPT_CRC16_EN
            byte_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            pay_q      <= pay_d;
            pid_q      <= pid_d;
            kind_q     <= kind_d;
            crc_q      <= crc_d;
            mode_q     <= mode_d;
            start_q    <= start_d;
            drop_cnt_q <= drop_cnt_d;
`ifdef USB_CRYPT_CRC16_EN
            byte_q     <= byte_d;
`endif
        end
    end

    assign fifo_wdata = {kind_q, pid_q, pay_q, crc_q};
    assign pop        = tx_valid && tx_ready;

    usb_pkt_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EntW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (fifo_wdata),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign tx_valid = !fifo_empty;
    assign {tx_kind, tx_pid, tx_payload, tx_crc} = fifo_rdata;

    assign enc_start = start_q;
    assign enc_mode  = mode_q;
    assign drop_cnt  = drop_cnt_q;
    assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_usb_crypt_seq.sv
// Scoreboard bench for usb_crypt_seq: a behavioural engine and packet model feed an expected
// queue that a monitor drains on every tx handshake.
module tb_usb_crypt_seq;

    localparam int unsigned BLOCKS      = 2;
    localparam int unsigned DEPTH       = 2;
    localparam int unsigned ENC_TIMEOUT = 16;
    localparam int unsigned PW          = 64 * BLOCKS;

    logic          clk = 1'b0;
    logic          rst;
    logic          rx_valid;
    logic [7:0]    rx_pid;
    logic [PW-1:0] rx_payload;
    logic [15:0]   rx_crc;
    logic          rx_crc_ok;
    logic          mode;
    logic          enc_start, enc_mode, enc_done;
    logic [63:0]   enc_din, enc_dout;
    logic          tx_valid, tx_ready;
    logic [7:0]    tx_pid, drop_cnt;
    logic [PW-1:0] tx_payload;
    logic [15:0]   tx_crc;
    logic [1:0]    tx_kind;
    logic          busy;

    always #5 clk = ~clk;

    usb_crypt_seq #(
        .BLOCKS      (BLOCKS),
        .DEPTH       (DEPTH),
        .ENC_TIMEOUT (ENC_TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_valid   (rx_valid),
        .rx_pid     (rx_pid),
        .rx_payload (rx_payload),
        .rx_crc     (rx_crc),
        .rx_crc_ok  (rx_crc_ok),
        .mode       (mode),
        .enc_start  (enc_start),
        .enc_mode   (enc_mode),
        .enc_din    (enc_din),
        .enc_done   (enc_done),
        .enc_dout   (enc_dout),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx_pid     (tx_pid),
        .tx_payload (tx_payload),
        .tx_crc     (tx_crc),
        .tx_kind    (tx_kind),
        .drop_cnt   (drop_cnt),
        .busy       (busy)
    );

    typedef struct {
        logic [1:0]    kind;
        logic [7:0]    pid;
        logic [PW-1:0] pay;
        logic [15:0]   crc;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0;
    int errors = 0;
    int drop_model = 0;
    int start_cnt = 0;
    int eng_en = 1;
    int eng_lat = 0;
    int stray_req = 0;
    int stray_ack = 0;
    int ready_mode = 1;

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] eng_f(input logic [63:0] d, input logic m);
        if (m) return d ^ 64'h0123_4567_89AB_CDEF;
        return {d[7:0], d[63:8]} ^ 64'hF0F0_0FF0_5A5A_3C3C;
    endfunction

    // -1 drop, 0 token, 1 data, 2 handshake
    function automatic int ref_kind(input logic [7:0] p);
        case (p)
            8'hC3, 8'h4B:                return 1;
            8'hE1, 8'h69, 8'h2D, 8'hA5:  return 0;
            8'hD2, 8'h5A, 8'h1E:         return 2;
            default:                     return -1;
        endcase
    endfunction

    function automatic logic [15:0] ref_crc(input logic [PW-1:0] p);
`ifdef USB_CRYPT_CRC16_EN
        logic [15:0] c;
        logic        fb;
        c = 16'hFFFF;
        for (int i = 0; i < PW; i++) begin
            fb = c[0] ^ p[i];
            c  = c >> 1;
            if (fb) c = c ^ 16'hA001;
        end
        return ~c;
`else
        return (p == p) ? 16'hFFFF : 16'h0000;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] pid, input logic [PW-1:0] pay, input logic [15:0] crc,
                        input logic ok, input logic m);
        tick();
        rx_valid   = 1'b1;
        rx_pid     = pid;
        rx_payload = pay;
        rx_crc     = crc;
        rx_crc_ok  = ok;
        mode       = m;
        tick();
        rx_valid   = 1'b0;
    endtask

    task automatic issue(input logic [7:0] pid, input logic [PW-1:0] pay, input logic [15:0] crc,
                         input logic ok, input logic m, input bit overrun);
        exp_t e;
        int   k;
        k = ref_kind(pid);
        if (overrun || k < 0 || (k == 1 && !ok)) begin
            if (drop_model < 255) drop_model++;
        end else begin
            e.kind = 2'(k);
            e.pid  = pid;
            e.pay  = '0;
            e.crc  = crc;
            if (k == 1) begin
                for (int b = 0; b < BLOCKS; b++) e.pay[b*64 +: 64] = eng_f(pay[b*64 +: 64], m);
                e.crc = ref_crc(e.pay);
            end
            exp_q.push_back(e);
        end
        send(pid, pay, crc, ok, m);
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin
            tick();
            n++;
        end
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: got busy %0d expected 0", busy);
        end
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
        end
    endtask

    function automatic logic [PW-1:0] rand_pay();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Behavioural DES stand-in with programmable latency.
    initial begin
        logic [63:0] d;
        logic        m;
        int          lat;
        enc_done = 1'b0;
        enc_dout = '0;
        forever begin
            @(negedge clk);
            if (stray_req != stray_ack) begin
                tick();
                enc_done = 1'b1;
                enc_dout = {$urandom(), $urandom()};
                tick();
                enc_done = 1'b0;
                stray_ack++;
            end else if (enc_start) begin
                start_cnt++;
                d = enc_din;
                m = enc_mode;
                if (eng_en != 0) begin
                    lat = (eng_lat != 0) ? eng_lat : int'($urandom_range(1, 6));
                    repeat (lat) @(posedge clk);
                    #1;
                    enc_done = 1'b1;
                    enc_dout = eng_f(d, m);
                    tick();
                    enc_done = 1'b0;
                end
            end
        end
    end

    initial begin
        tx_ready = 1'b0;
        forever begin
            tick();
            case (ready_mode)
                0:       tx_ready = 1'b0;
                1:       tx_ready = 1'b1;
                default: tx_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    initial begin
        exp_t         e;
        logic         hold;
        logic [153:0] prev;
        hold = 1'b0;
        prev = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                hold = 1'b0;
            end else begin
                if (hold && tx_valid) check("tx_hold", {tx_kind, tx_pid, tx_payload, tx_crc}, prev);
                if (tx_valid && tx_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL tx_unexpected: got pid %h expected none", tx_pid);
                    end else begin
                        e = exp_q.pop_front();
                        check("tx_kind", tx_kind, e.kind);
                        check("tx_pid", tx_pid, e.pid);
                        check("tx_crc", tx_crc, e.crc);
                        if (e.kind == 2'b01) check("tx_payload", tx_payload, e.pay);
                    end
                end
                hold = tx_valid && !tx_ready;
                prev = {tx_kind, tx_pid, tx_payload, tx_crc};
            end
        end
    end

    initial begin
        logic [PW-1:0] pay;
        logic [7:0]    pid;
        int            s0, r;
        rst        = 1'b1;
        rx_valid   = 1'b0;
        rx_pid     = '0;
        rx_payload = '0;
        rx_crc     = '0;
        rx_crc_ok  = 1'b0;
        mode       = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        check("rst_enc_start", enc_start, 0);
        check("rst_enc_mode", enc_mode, 0);
        check("rst_enc_din", enc_din, 0);
        check("rst_tx_valid", tx_valid, 0);
        check("rst_tx_pid", tx_pid, 0);
        check("rst_tx_payload", tx_payload, 0);
        check("rst_tx_crc", tx_crc, 0);
        check("rst_tx_kind", tx_kind, 0);
        check("rst_drop_cnt", drop_cnt, 0);
        check("rst_busy", busy, 0);

        issue(8'hC4, rand_pay(), 16'h0, 1'b1, 1'b0, 1'b0);
        check("drop_bad_pid", drop_cnt, drop_model);
        issue(8'h4B, rand_pay(), 16'h0, 1'b0, 1'b1, 1'b0);
        check("drop_bad_crc", drop_cnt, 2);
        tick();
        check("drop_no_tx", tx_valid, 0);

        ready_mode = 0;
        wait_idle(50);
        s0 = start_cnt;
        issue(8'h69, rand_pay(), 16'h1234, 1'b1, 1'b0, 1'b0);
        check("tok_busy_push", busy, 1);
        tick();
        check("tok_valid_t2", tx_valid, 1);
        check("tok_kind", tx_kind, 2'b00);
        check("tok_crc", tx_crc, 16'h1234);
        ready_mode = 1;
        wait_drain(50);
        check("tok_no_start", start_cnt - s0, 0);

        eng_lat = 5;
        wait_idle(50);
        pay = rand_pay();
        s0  = start_cnt;
        issue(8'hC3, pay, 16'hBEEF, 1'b1, 1'b1, 1'b0);
        check("data_start_t1", enc_start, 1);
        check("data_din_blk0", enc_din, pay[63:0]);
        check("data_mode", enc_mode, 1);
        wait_drain(200);
        check("data_start_cnt", start_cnt - s0, BLOCKS);
        eng_lat = 0;

        ready_mode = 0;
        wait_idle(50);
        issue(8'hE1, rand_pay(), 16'h1111, 1'b1, 1'b0, 1'b0);
        repeat (3) tick();
        issue(8'h2D, rand_pay(), 16'h2222, 1'b1, 1'b0, 1'b0);
        repeat (3) tick();
        issue(8'hA5, rand_pay(), 16'h3333, 1'b1, 1'b0, 1'b0);
        repeat (3) tick();
        check("full_stall_busy", busy, 1);
        check("full_tx_valid", tx_valid, 1);
        issue(8'hD2, rand_pay(), 16'h4444, 1'b1, 1'b0, 1'b1);
        check("overrun_drop", drop_cnt, drop_model);
        ready_mode = 1;
        wait_drain(100);
        wait_idle(50);
        check("drain_idle", busy, 0);

        eng_en = 0;
        wait_idle(50);
        send(8'hC3, rand_pay(), 16'h0, 1'b1, 1'b0);
        repeat (ENC_TIMEOUT) tick();
        check("to_last_wait", busy, 1);
        tick();
        check("to_idle", busy, 0);
        drop_model++;
        check("to_drop", drop_cnt, drop_model);
        eng_en = 1;

        ready_mode = 2;
        for (int i = 0; i < 40; i++) begin
            wait_idle(300);
            r = int'($urandom_range(0, 8));
            case (r)
                0, 1, 2, 3: pid = ($urandom_range(0, 1) != 0) ? 8'hC3 : 8'h4B;
                4, 5:       pid = ($urandom_range(0, 1) != 0) ? 8'h69 : 8'hE1;
                6:          pid = ($urandom_range(0, 1) != 0) ? 8'h5A : 8'h1E;
                7:          pid = ($urandom_range(0, 1) != 0) ? 8'hC3 : 8'h4B;
                default:    pid = 8'($urandom_range(0, 255));
            endcase
            issue(pid, rand_pay(), 16'($urandom()), (r == 7) ? 1'b0 : 1'($urandom_range(0, 1) | 1),
                  1'($urandom_range(0, 1)), 1'b0);
            check("rand_drop_cnt", drop_cnt, drop_model);
        end
        ready_mode = 1;
        wait_idle(300);
        wait_drain(300);

        ready_mode = 0;
        wait_idle(50);
        issue(8'hE1, rand_pay(), 16'h5555, 1'b1, 1'b0, 1'b0);
        repeat (3) tick();
        eng_en = 0;
        issue(8'hC3, rand_pay(), 16'h0, 1'b1, 1'b1, 1'b0);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.delete();
        drop_model = 0;
        check("mid_rst_tx_valid", tx_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_drop", drop_cnt, 0);
        check("mid_rst_start", enc_start, 0);
        check("mid_rst_tx_pid", tx_pid, 0);
        ready_mode = 1;
        stray_req++;
        repeat (4) tick();
        check("stray_busy", busy, 0);
        check("stray_tx_valid", tx_valid, 0);
        check("stray_din", enc_din, 0);
        check("stray_drop", drop_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
